// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix bank: command encodings, controller states
// and the storage address mapping.
package matrix_pkg;

    // Encoding 2'b11 is reserved and rejected by the controller.
    localparam logic [1:0] OP_LOAD      = 2'b00;
    localparam logic [1:0] OP_DRAIN_ROW = 2'b01;
    localparam logic [1:0] OP_DRAIN_COL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Rows are strided by the maximum column count, so a matrix's layout does
    // not depend on the column count it was loaded with.
    function automatic int unsigned mat_addr(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned col_w);
        return (row << col_w) | col;
    endfunction

endpackage

// File: rtl/matrix_ram.sv
// Single-channel element store: one write port, one read port, one-cycle read.
module matrix_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/matrix_bank.sv
// Bank of NUM_CH matrix stores: streams a matrix in row-major order and drains
// it back out row-major or transposed through a two-entry output buffer.
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 5,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [ROW_W:0]    cfg_rows,
    input  logic [COL_W:0]    cfg_cols,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam logic [ROW_W:0]   ROWS_MAX = {1'b1, {ROW_W{1'b0}}};
    localparam logic [COL_W:0]   COLS_MAX = {1'b1, {COL_W{1'b0}}};
    localparam logic [ROW_W:0]   ROWS_ONE = {{ROW_W{1'b0}}, 1'b1};
    localparam logic [COL_W:0]   COLS_ONE = {{COL_W{1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0] R_INC    = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0] C_INC    = {{(COL_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              trans_q, trans_d;
    logic [ROW_W-1:0]  rmax_q, rmax_d, r_q, r_d;
    logic [COL_W-1:0]  cmax_q, cmax_d, c_q, c_d;
    logic              err_q, err_d;
    logic              pend_q, pend_last_q, pend_last_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic              buf_last_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;

    logic              cmd_legal, at_end, pop, room, wr_en, rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata_all [2**CH_W];
    logic [DATA_W-1:0] rdata_sel;

    assign cmd_legal = (cmd_op inside {OP_LOAD, OP_DRAIN_ROW, OP_DRAIN_COL})
                    && (int'(cmd_ch) < NUM_CH)
                    && (cfg_rows != '0) && (cfg_rows <= ROWS_MAX)
                    && (cfg_cols != '0) && (cfg_cols <= COLS_MAX);

    assign at_end    = (r_q == rmax_q) && (c_q == cmax_q);
    assign addr      = ADDR_W'(mat_addr(32'(r_q), 32'(c_q), COL_W));
    assign rdata_sel = rdata_all[ch_q];

    assign m_valid   = (cnt_q != 2'd0);
    assign m_data    = buf_data_q[rd_ptr_q];
    assign m_last    = m_valid && buf_last_q[rd_ptr_q];
    assign pop       = m_valid && m_ready;
    // Occupancy counts the read still in flight, less the element leaving now.
    assign cnt_d     = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    assign room      = (cnt_d < 2'd2);

    assign cmd_ready = (state_q == ST_IDLE);
    assign s_ready   = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic sel;
        assign sel = (ch_q == CH_W'(gi));
        matrix_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
            .clk_i   (CLK),
            .we_i    (wr_en && sel),
            .waddr_i (addr),
            .wdata_i (s_data),
            .re_i    (rd_en && sel),
            .raddr_i (addr),
            .rdata_o (rdata_all[gi])
        );
    end
    for (genvar gi = NUM_CH; gi < 2**CH_W; gi++) begin : g_pad
        assign rdata_all[gi] = '0;
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        trans_d = trans_q;
        rmax_d  = rmax_q;
        cmax_d  = cmax_q;
        r_d     = r_q;
        c_d     = c_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_legal) begin
                        err_d = 1'b1;
                    end else begin
                        ch_d    = cmd_ch;
                        trans_d = (cmd_op == OP_DRAIN_COL);
                        rmax_d  = ROW_W'(cfg_rows - ROWS_ONE);
                        cmax_d  = COL_W'(cfg_cols - COLS_ONE);
                        r_d     = '0;
                        c_d     = '0;
                        state_d = (cmd_op == OP_LOAD) ? ST_LOAD : ST_DRAIN;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (at_end) state_d = ST_IDLE;
                    if (c_q == cmax_q) begin
                        c_d = '0;
                        r_d = r_q + R_INC;
                    end else begin
                        c_d = c_q + C_INC;
                    end
                end
            end
            ST_DRAIN: begin
                if (room) begin
                    rd_en = 1'b1;
                    if (at_end) state_d = ST_FLUSH;
                    if (trans_q) begin
                        if (r_q == rmax_q) begin
                            r_d = '0;
                            c_d = c_q + C_INC;
                        end else begin
                            r_d = r_q + R_INC;
                        end
                    end else if (c_q == cmax_q) begin
                        c_d = '0;
                        r_d = r_q + R_INC;
                    end else begin
                        c_d = c_q + C_INC;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && m_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pend_last_d = rd_en && at_end;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            trans_q       <= 1'b0;
            rmax_q        <= '0;
            cmax_q        <= '0;
            r_q           <= '0;
            c_q           <= '0;
            err_q         <= 1'b0;
            pend_q        <= 1'b0;
            pend_last_q   <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            trans_q     <= trans_d;
            rmax_q      <= rmax_d;
            cmax_q      <= cmax_d;
            r_q         <= r_d;
            c_q         <= c_d;
            err_q       <= err_d;
            pend_q      <= rd_en;
            pend_last_q <= pend_last_d;
            cnt_q       <= cnt_d;
            if (pend_q) begin
                buf_data_q[wr_ptr_q] <= rdata_sel;
                buf_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q             <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

endmodule
